gpio_reg_scan_array: RTL and testbench
======================================

Name: gpio_reg_scan_array

Overview:
- Parametrised successor to the fixed 20-register GPIO array.
- Continuously sweeps a bank of NUM_REGS registers through the AXI BRAM controller port.
  - Input-direction registers are written into BRAM.
  - Output-direction registers are read from BRAM into shadow registers.
- All outputs commit atomically at end of sweep, so PS software sees coherent multi-register updates.
- Adds a busy-aware stall, a scan enable and a sweep-done strobe.

Parameters:
- NUM_REGS, 20, number of 32-bit register slots (1..256).
- REG_WIDTH, 32, valid bits per register (1..32); upper BRAM bits write as 0 and are ignored on read.
- BRAM_WIDTH, 11, byte-address width; requires NUM_REGS*4 <= 2**BRAM_WIDTH.
- DIR_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i an input (fabric -> BRAM).
- RESET_VAL, 0, value loaded into every output slot and shadow on reset.

Ports:
- aclk  in  1  sole clock.
- areset  in  1  synchronous, active-high reset.
- scan_en  in  1  level; enables sweeping.
- BRAM_addr  out  BRAM_WIDTH  byte address = index*4.
- BRAM_wrdata  out  32  zero-extended input register value.
- BRAM_rddata  in  32  read data, valid one cycle after read issue.
- BRAM_en  out  1  access strobe.
- BRAM_we  out  4  4'hF on write, 4'h0 on read.
- BRAM_clk  out  1  = aclk.
- BRAM_rst  out  1  = areset.
- BRAM_busy  in  1  PS side owns BRAM; no new access issued.
- in_bus  in  NUM_REGS*REG_WIDTH  slice i = register i input.
- out_bus  out  NUM_REGS*REG_WIDTH  slice i = committed register i.
- sweep_done  out  1  one-cycle pulse on commit.

Behaviour:
- Reset (synchronous, areset=1 at a rising edge):
  - state=IDLE, index=0.
  - out_bus and shadows = RESET_VAL.
  - BRAM_en=0, BRAM_we=0, BRAM_addr=0, BRAM_wrdata=0, sweep_done=0.
  - Mid-sweep reset discards the partial sweep; nothing commits.
- FSM states IDLE, ISSUE, CAPTURE, COMMIT.
- IDLE: if scan_en=1 and BRAM_busy=0, go to ISSUE with index=0.
- ISSUE:
  - If BRAM_busy=1: BRAM_en=0, hold state and index.
  - Otherwise assert BRAM_en, BRAM_addr=index*4, and go to CAPTURE.
  - Input register: we=4'hF, wrdata=in_bus slice, sampled this cycle.
  - Output register: we=0.
- CAPTURE:
  - BRAM_en=0.
  - Output register: shadow[index] <= BRAM_rddata[REG_WIDTH-1:0].
  - Input register: shadow[index] <= value written.
  - A capture already issued always completes, even if BRAM_busy rises.
  - If index==NUM_REGS-1, go to COMMIT; else index+1 and go to ISSUE.
- COMMIT:
  - out_bus <= all shadows in one cycle.
  - sweep_done=1 for this cycle.
  - If scan_en=1, go to ISSUE with index=0 (wrap); else go to IDLE.
- Latency: 2 cycles per register, so a sweep takes 2*NUM_REGS+1 cycles with no busy stalls.
- scan_en deasserted mid-sweep: the current sweep finishes and commits, then the FSM idles.
- Input slices on out_bus mirror the in_bus value last written to BRAM (loopback).

Optional Feature:
- Macro: GPIO_REG_CHANGE_IRQ_EN.
- Defined: adds ports irq (out 1), irq_ack (in 1) and changed (out NUM_REGS).
  - At COMMIT, changed[i] is set (sticky) for each output register whose new value differs from the previously committed value.
  - irq = |changed.
  - irq_ack=1 clears changed in the next cycle.
  - A COMMIT in the same cycle as irq_ack wins for newly changed bits.
  - Reset clears changed.
- Undefined: ports absent, no change-tracking logic.

Decomposition:
- Package gpio_reg_pkg holds:
  - the FSM state enum;
  - constants WE_ALL=4'hF and WE_NONE=4'h0;
  - function slice_lsb(i)=i*REG_WIDTH.
- One sub-module, gpio_reg_change_detect: the per-register compare plus sticky flag vector, instantiated only under the macro.

Test Plan:
- Reset then idle: areset=1 for 3 cycles with scan_en=0 -> out_bus all RESET_VAL, BRAM_en never 1, sweep_done 0.
- Basic sweep (NUM_REGS=4, DIR_MASK=4'b0001):
  - Stimulus: in slice0=32'hFFFF_FFFF; rddata returns 32'h2222_2222, 32'h3333_3333 and 32'h4444_4444 for addresses 4, 8 and 12.
  - Response: write to address 0 with wrdata FFFF_FFFF; out slices 1..3 update only at sweep_done, exactly cycle 9 after start.
- Busy stall: BRAM_busy=1 for 5 cycles during ISSUE of index 2 -> BRAM_en low throughout, index held, sweep length 14 cycles, values still correct.
- Atomicity: rddata for register 1 changes between sweeps -> out_bus slice 1 never shows a partial or intermediate value; changes only on the sweep_done cycle.
- Reset mid-sweep: areset asserted during CAPTURE of index 2 -> out_bus keeps RESET_VAL, no sweep_done; the next sweep restarts at address 0.
- GPIO_REG_CHANGE_IRQ_EN defined:
  - Register 3 value goes 5 -> 6 across sweeps -> changed=4'b1000 and irq=1 after commit.
  - irq_ack pulse -> changed=0 the next cycle.

Source files
------------

// File: rtl/gpio_reg_pkg.sv
// Shared types and helpers for the GPIO register scan array.
// FSM encoding, BRAM byte-enable constants and bus slice arithmetic.
package gpio_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    COMMIT
  } state_t;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  function automatic int slice_lsb(input int i, input int width);
    return i * width;
  endfunction

endpackage

// File: rtl/gpio_reg_change_detect.sv
// Sticky per-register change flags for output registers, raised when a commit alters a value.
// Latency: flags update one cycle after the commit; irq is a combinational OR of the flags.
// Backpressure: none; irq_ack clears the flags, and a simultaneous commit re-raises new changes.
module gpio_reg_change_detect
  import gpio_reg_pkg::*;
#(
  parameter int                  NUM_REGS  = 20,
  parameter int                  REG_WIDTH = 32,
  parameter logic [NUM_REGS-1:0] DIR_MASK  = '0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          commit,
  input  logic                          irq_ack,
  input  logic [NUM_REGS*REG_WIDTH-1:0] old_bus,
  input  logic [NUM_REGS*REG_WIDTH-1:0] new_bus,
  output logic [NUM_REGS-1:0]           changed,
  output logic                          irq
);

  logic [NUM_REGS-1:0] diff;

  always_comb begin
    diff = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      diff[i] = !DIR_MASK[i] &&
                (old_bus[slice_lsb(i, REG_WIDTH) +: REG_WIDTH] !=
                 new_bus[slice_lsb(i, REG_WIDTH) +: REG_WIDTH]);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      changed <= '0;
    end else begin
      changed <= (irq_ack ? '0 : changed) | (commit ? diff : '0);
    end
  end

  assign irq = |changed;

endmodule

// File: rtl/gpio_reg_scan_array.sv
// Sweeps NUM_REGS registers through a BRAM port; outputs commit atomically at end of sweep.
// Latency: 2 cycles per register plus 1 commit cycle per sweep (2*NUM_REGS+1 without stalls).
// Backpressure: BRAM_busy holds the FSM in ISSUE with no access; GPIO_REG_CHANGE_IRQ_EN adds change irq.
module gpio_reg_scan_array
  import gpio_reg_pkg::*;
#(
  parameter int                   NUM_REGS   = 20,
  parameter int                   REG_WIDTH  = 32,
  parameter int                   BRAM_WIDTH = 11,
  parameter logic [NUM_REGS-1:0]  DIR_MASK   = '0,
  parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          scan_en,
  output logic [BRAM_WIDTH-1:0]         BRAM_addr,
  output logic [31:0]                   BRAM_wrdata,
  input  logic [31:0]                   BRAM_rddata,
  output logic                          BRAM_en,
  output logic [3:0]                    BRAM_we,
  output logic                          BRAM_clk,
  output logic                          BRAM_rst,
  input  logic                          BRAM_busy,
  input  logic [NUM_REGS*REG_WIDTH-1:0] in_bus,
  output logic [NUM_REGS*REG_WIDTH-1:0] out_bus,
`ifdef GPIO_REG_CHANGE_IRQ_EN
  output logic                          irq,
  input  logic                          irq_ack,
  output logic [NUM_REGS-1:0]           changed,
`endif
  output logic                          sweep_done
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t                 state;
  logic [IDX_W-1:0]       index;
  logic [REG_WIDTH-1:0]   wr_hold;
  logic [REG_WIDTH-1:0]   shadow   [NUM_REGS];
  logic [REG_WIDTH-1:0]   in_slice [NUM_REGS];
  logic [NUM_REGS*REG_WIDTH-1:0] shadow_flat;
  logic                   is_input;
  logic                   fire;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slice
    assign in_slice[g] = in_bus[slice_lsb(g, REG_WIDTH) +: REG_WIDTH];
    assign shadow_flat[slice_lsb(g, REG_WIDTH) +: REG_WIDTH] = shadow[g];
  end

  assign BRAM_clk = aclk;
  assign BRAM_rst = areset;
  assign is_input = DIR_MASK[index];
  // Busy must suppress the strobe in the same cycle, so the access decode is combinational.
  assign fire     = (state == ISSUE) && !BRAM_busy;

  always_comb begin
    BRAM_en     = fire;
    BRAM_addr   = BRAM_WIDTH'({index, 2'b00});
    BRAM_we     = (fire && is_input) ? WE_ALL : WE_NONE;
    BRAM_wrdata = '0;
    if (fire && is_input) begin
      BRAM_wrdata[REG_WIDTH-1:0] = in_slice[index];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      index      <= '0;
      wr_hold    <= '0;
      sweep_done <= 1'b0;
      out_bus    <= {NUM_REGS{RESET_VAL}};
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VAL;
      end
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_en && !BRAM_busy) begin
            state <= ISSUE;
            index <= '0;
          end
        end
        ISSUE: begin
          if (!BRAM_busy) begin
            wr_hold <= in_slice[index];
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          shadow[index] <= is_input ? wr_hold : BRAM_rddata[REG_WIDTH-1:0];
          if (index == LAST_IDX) begin
            state      <= COMMIT;
            sweep_done <= 1'b1;
          end else begin
            index <= index + 1'b1;
            state <= ISSUE;
          end
        end
        COMMIT: begin
          out_bus <= shadow_flat;
          index   <= '0;
          state   <= scan_en ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPIO_REG_CHANGE_IRQ_EN
  logic commit_now;
  assign commit_now = (state == COMMIT);

  gpio_reg_change_detect #(
    .NUM_REGS (NUM_REGS),
    .REG_WIDTH(REG_WIDTH),
    .DIR_MASK (DIR_MASK)
  ) u_change_detect (
    .aclk   (aclk),
    .areset (areset),
    .commit (commit_now),
    .irq_ack(irq_ack),
    .old_bus(out_bus),
    .new_bus(shadow_flat),
    .changed(changed),
    .irq    (irq)
  );
`endif

endmodule

// File: tb/tb_gpio_reg_scan_array.sv
// Bench for gpio_reg_scan_array: BRAM model, scoreboard of committed sweeps and protocol monitor.
module tb_gpio_reg_scan_array;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 11;
  localparam int CW = N * W;
  localparam logic [N-1:0] DMASK = 4'b0001;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          scan_en = 1'b0;
  logic          BRAM_busy = 1'b0;
  logic [AW-1:0] BRAM_addr;
  logic [31:0]   BRAM_wrdata;
  logic [31:0]   BRAM_rddata;
  logic          BRAM_en;
  logic [3:0]    BRAM_we;
  logic          BRAM_clk;
  logic          BRAM_rst;
  logic [CW-1:0] in_bus = '0;
  logic [CW-1:0] out_bus;
  logic          sweep_done;
`ifdef GPIO_REG_CHANGE_IRQ_EN
  logic          irq;
  logic          irq_ack = 1'b0;
  logic [N-1:0]  changed;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0]   ps_mem [N];
  logic [CW-1:0] exp_q [$];

  gpio_reg_scan_array #(
    .NUM_REGS  (N),
    .REG_WIDTH (W),
    .BRAM_WIDTH(AW),
    .DIR_MASK  (DMASK),
    .RESET_VAL (32'h0)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .scan_en    (scan_en),
    .BRAM_addr  (BRAM_addr),
    .BRAM_wrdata(BRAM_wrdata),
    .BRAM_rddata(BRAM_rddata),
    .BRAM_en    (BRAM_en),
    .BRAM_we    (BRAM_we),
    .BRAM_clk   (BRAM_clk),
    .BRAM_rst   (BRAM_rst),
    .BRAM_busy  (BRAM_busy),
    .in_bus     (in_bus),
    .out_bus    (out_bus),
`ifdef GPIO_REG_CHANGE_IRQ_EN
    .irq        (irq),
    .irq_ack    (irq_ack),
    .changed    (changed),
`endif
    .sweep_done (sweep_done)
  );

  always #5 aclk = ~aclk;

  // BRAM read port: data returns one cycle after the access.
  always @(posedge aclk) begin
    if (BRAM_en) BRAM_rddata <= ps_mem[BRAM_addr[3:2]];
  end

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected committed image: inputs loop back, outputs mirror the PS-side BRAM words.
  function automatic logic [CW-1:0] model_out();
    logic [CW-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = DMASK[i] ? in_bus[i*W +: W] : ps_mem[i];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      ps_mem[i]        = $urandom();
      in_bus[i*W +: W] = $urandom();
    end
  endtask

  // Starts one sweep; busy_at/rst_at are cycle offsets (<=0 disables them).
  task automatic sweep(input string name, input int busy_at, input int rst_at, input int exp_len);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    if (rst_at <= 0) exp_q.push_back(model_out());
    scan_en = 1'b1;
    while (!done && n < 200) begin
      step();
      n++;
      if (n == 1) scan_en = 1'b0;
      if (n == busy_at) BRAM_busy = 1'b1;
      if (busy_at > 0 && n == busy_at + 6) BRAM_busy = 1'b0;
      if (n == rst_at) begin
        areset = 1'b1;
        step();
        areset = 1'b0;
        return;
      end
      if (sweep_done === 1'b1) done = 1'b1;
    end
    check(name, n, exp_len);
  endtask

  // Monitor: scoreboard pops on sweep_done, plus BRAM protocol and out_bus stability checks.
  initial begin
    logic [CW-1:0] prev_out;
    logic [CW-1:0] exp_pending;
    bit            pending;
    bit            started;
    bit            prev_done;
    bit            prev_rst;
    int            acc_idx;
    pending   = 1'b0;
    started   = 1'b0;
    prev_done = 1'b0;
    prev_rst  = 1'b1;
    acc_idx   = 0;
    forever begin
      @(negedge aclk);
      if (pending) begin
        check("commit_value", out_bus, exp_pending);
        pending = 1'b0;
      end
      if (started && !prev_done && !prev_rst) check("out_stable", out_bus, prev_out);
      if (sweep_done === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_sweep_done: got pulse expected none at %0t", $time);
        end else begin
          exp_pending = exp_q.pop_front();
          pending     = 1'b1;
        end
      end
      check("bram_rst", BRAM_rst, areset);
      if (BRAM_busy) check("en_while_busy", BRAM_en, 1'b0);
      if (BRAM_en === 1'b1) begin
        check("acc_addr", BRAM_addr, acc_idx * 4);
        check("acc_we", BRAM_we, DMASK[acc_idx] ? 4'hF : 4'h0);
        if (DMASK[acc_idx]) check("acc_wrdata", BRAM_wrdata, in_bus[acc_idx*W +: W]);
        acc_idx = (acc_idx + 1) % N;
      end
      if (areset) acc_idx = 0;
      prev_out  = out_bus;
      prev_done = (sweep_done === 1'b1);
      prev_rst  = areset;
      started   = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef GPIO_REG_CHANGE_IRQ_EN
    logic [CW-1:0] before;
    logic [N-1:0]  exp_chg;
`endif
    for (int i = 0; i < N; i++) ps_mem[i] = '0;

    // Reset held for 3 cycles with scanning disabled.
    repeat (3) begin
      step();
      check("rst_en", BRAM_en, 1'b0);
      check("rst_done", sweep_done, 1'b0);
      check("rst_out", out_bus, '0);
    end
    areset = 1'b0;
    check("rst_addr", BRAM_addr, '0);
    check("rst_wrdata", BRAM_wrdata, '0);
    check("rst_we", BRAM_we, '0);
    repeat (5) begin
      step();
      check("idle_en", BRAM_en, 1'b0);
      check("idle_done", sweep_done, 1'b0);
    end

    // Basic sweep with fixed values; scan_en drops after one cycle but the sweep completes.
    in_bus[31:0] = 32'hFFFF_FFFF;
    ps_mem[1] = 32'h2222_2222;
    ps_mem[2] = 32'h3333_3333;
    ps_mem[3] = 32'h4444_4444;
    sweep("basic_len", 0, 0, 9);
    repeat (3) step();

    // Busy stall of 5 cycles on the ISSUE of index 2.
    randomize_data();
    sweep("busy_len", 4, 0, 14);
    repeat (2) step();

    // Back-to-back sweeps with register 1 (and others) changing between sweeps.
    for (int k = 0; k < 6; k++) begin
      randomize_data();
      sweep("cont_len", 0, 0, 9);
    end
    repeat (3) step();

    // Reset during CAPTURE of index 2: nothing commits.
    randomize_data();
    sweep("mid_reset", 0, 6, 0);
    repeat (10) begin
      step();
      check("post_rst_done", sweep_done, 1'b0);
      check("post_rst_out", out_bus, '0);
    end
    randomize_data();
    sweep("restart_len", 0, 0, 9);
    repeat (3) step();

`ifdef GPIO_REG_CHANGE_IRQ_EN
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_clear0", changed, '0);
    ps_mem[3] = 32'd5;
    sweep("irq_len5", 0, 0, 9);
    repeat (2) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_clear1", changed, '0);
    before = model_out();
    ps_mem[3] = 32'd6;
    exp_chg = '0;
    for (int i = 0; i < N; i++) begin
      exp_chg[i] = !DMASK[i] && (before[i*W +: W] != model_out() >> (i*W) & CW'(32'hFFFF_FFFF));
    end
    sweep("irq_len6", 0, 0, 9);
    step();
    check("changed_set", changed, exp_chg);
    check("changed_r3", changed, 4'b1000);
    check("irq_set", irq, 1'b1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_clear2", changed, '0);
    check("irq_clear", irq, 1'b0);
`endif

    repeat (4) step();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
